mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer sharing one multi-cycle memory port between the core's instruction-fetch path and its load/store path. Sits between the RISC-V core (fetch unit, LSU) and a unified memory with request/ready and response-valid handshakes. Grants by fixed priority (data over fetch), prevents fetch starvation with a burst counter, and recovers from a non-responding memory with a timeout error response.

## Interface
Parameters:
- TIMEOUT, 16: max cycles spent in ISSUE+WAIT before a forced error response (>=2).
- MAX_D_BURST, 4: consecutive data grants allowed while fetch is pending (>=1).

Ports:
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle response pulse for fetch.
- i_rdata  out  32  fetch data, valid while i_ack=1.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store.
- d_size  in  3  access size (funct3 encoding, as the data memory uses).
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle response pulse for data.
- d_rdata  out  32  load data, valid while d_ack=1.
- err  out  1  response flag, valid with i_ack/d_ack; 1 = timeout.
- busy  out  1  1 whenever state != IDLE.
- mem_req  out  1  request to memory.
- mem_we, mem_size(3), mem_addr(32), mem_wdata(32)  out  request payload, registered.
- mem_ready  in  1  memory accepts when mem_req & mem_ready.
- mem_valid  in  1  response strobe.
- mem_rdata  in  32  response data, valid with mem_valid.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registered owner bit (I/D).
- IDLE: if neither req -> stay. Else choose owner; latch payload into mem_* regs; -> ISSUE. Fetch grant drives mem_we=0, mem_size=3'b010, mem_wdata=0.
- Priority: d_req wins unless i_req=1 and burst_cnt==MAX_D_BURST, then fetch wins.
- burst_cnt: on D grant with i_req=1 -> +1; on D grant with i_req=0 -> 0; on I grant -> 0. Saturates at MAX_D_BURST.
- ISSUE: mem_req=1. mem_ready=1 -> WAIT. mem_valid ignored here.
- WAIT: mem_req=0. mem_valid=1 -> capture mem_rdata into owner's rdata reg, err=0, -> RESP.
- Timeout: tmo_cnt cleared on entering ISSUE, +1 each ISSUE/WAIT cycle; when it reaches TIMEOUT-1 without acceptance/response -> RESP with err=1, rdata=0, mem_req dropped.
- RESP: owner's ack=1 for exactly one cycle; other ack=0; both req ignored; -> IDLE.
- Requester drops req the cycle after ack; re-asserted req in the next IDLE cycle is a new transaction.
- mem_valid outside WAIT (incl. late response after timeout) is ignored, no state change.
- rst: state IDLE, mem_req=0, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_rdata=d_rdata=0, err=0, busy=0, burst_cnt=0, tmo_cnt=0. Reset mid-transaction abandons it with no ack.

## Timing
- All outputs registered/state-decoded; no combinational input->output path.
- Zero-wait memory (mem_ready=1, mem_valid one cycle after acceptance): req sampled in IDLE at cycle 0 -> mem_req=1 cycle 1 -> WAIT cycle 2 (mem_valid) -> ack cycle 3. Latency 3 cycles; back-to-back throughput one transaction per 4 cycles.
- Each ready wait cycle adds 1; each response wait cycle adds 1.
- Timeout ack arrives TIMEOUT+1 cycles after the IDLE grant cycle.
- rdata/err hold their value after ack until next ack or reset.

## Test plan
- Single fetch, zero-wait: i_req, i_addr=0x10, mem_rdata=0x00500093 -> mem_req cycle 1 with mem_addr=0x10, mem_we=0, mem_size=3'b010; i_ack cycle 3, i_rdata=0x00500093, err=0.
- Store with waits: d_req, d_we=1, d_size=3'b010, d_addr=0x104, d_wdata=0xDEADBEEF, mem_ready low 2 cycles, mem_valid 3 cycles later -> payload stable throughout ISSUE, exactly one d_ack, i_ack stays 0.
- Simultaneous: i_req and d_req both asserted at cycle 0 -> data granted first; fetch granted after d_ack.
- Starvation: i_req held, d_req re-asserted after every ack, MAX_D_BURST=4 -> four d_acks then i_ack, then data again.
- Timeout: TIMEOUT=16, mem_ready=1, no mem_valid -> ack 17 cycles after grant with err=1, rdata=0; late mem_valid in next IDLE ignored.
- Reset in WAIT: rst one cycle -> no ack, busy=0, mem_req=0, next request serviced normally with 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and load/store.
// Data has fixed priority, bounded by a burst limit so a pending fetch is never starved.
module mem_port_arbiter #(
    parameter int TIMEOUT     = 16,
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          owner_d_q, owner_d_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_we_q, mem_we_d;
    logic [2:0]    mem_size_q, mem_size_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          grant_d;
    logic          tmo_expire;

    assign grant_d = d_req && !(i_req && (burst_q == BURST_MAX));

    // A response arriving in the final allowed cycle still wins over the timeout.
    assign tmo_expire = ((state_q == ISSUE) || (state_q == WAIT && !mem_valid))
                        && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        burst_d     = burst_q;
        tmo_d       = tmo_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        if (tmo_expire) begin
            state_d = RESP;
            err_d   = 1'b1;
            if (owner_d_q) d_rdata_d = '0;
            else           i_rdata_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_d   = ISSUE;
                        tmo_d     = '0;
                        owner_d_d = grant_d;
                        if (grant_d) begin
                            mem_we_d    = d_we;
                            mem_size_d  = d_size;
                            mem_addr_d  = d_addr;
                            mem_wdata_d = d_wdata;
                            if (!i_req)                   burst_d = '0;
                            else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
                        end else begin
                            mem_we_d    = 1'b0;
                            mem_size_d  = 3'b010;
                            mem_addr_d  = i_addr;
                            mem_wdata_d = '0;
                            burst_d     = '0;
                        end
                    end
                end
                ISSUE: begin
                    tmo_d = tmo_q + 1'b1;
                    if (mem_ready) state_d = WAIT;
                end
                WAIT: begin
                    tmo_d = tmo_q + 1'b1;
                    if (mem_valid) begin
                        state_d = RESP;
                        err_d   = 1'b0;
                        if (owner_d_q) d_rdata_d = mem_rdata;
                        else           i_rdata_d = mem_rdata;
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            burst_q     <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            burst_q     <= burst_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign i_ack     = (state_q == RESP) && !owner_d_q;
    assign d_ack     = (state_q == RESP) && owner_d_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline model predicts every output each
// cycle; an ack log is then pinned against hand-computed cycles and data.
module tb_mem_port_arbiter;

    localparam int T    = 16;
    localparam int MAXB = 4;
    localparam int NCYC = 115;
    localparam int RST_AT = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ready, mem_valid;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_size;
    logic        i_ack, d_ack, err, busy, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_size;

    mem_port_arbiter #(.TIMEOUT(T), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          d;
        bit          we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          start;
        int          rd;     // cycles mem_ready stays low in ISSUE
        int          vd;     // WAIT cycles before mem_valid; <0 = never answers
        bit          late;   // send a stray mem_valid right after a timeout ack
    } txn_t;

    typedef struct {
        int          cyc;
        bit          d;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    txn_t iq[$], dq[$];
    ack_t alog[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit          e_busy, e_mreq, e_iack, e_dack, e_err, e_mwe;
    logic [2:0]  e_msize;
    logic [31:0] e_irdata, e_drdata, e_maddr, e_mwdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", nm, cyc, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit d, input bit we, input logic [2:0] sz,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int start, input int rd,
                                input int vd, input bit late);
        txn_t t;
        t.d = d; t.we = we; t.size = sz; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.start = start; t.rd = rd; t.vd = vd; t.late = late;
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),     32'(e_busy));
            chk("mem_req",   32'(mem_req),  32'(e_mreq));
            chk("i_ack",     32'(i_ack),    32'(e_iack));
            chk("d_ack",     32'(d_ack),    32'(e_dack));
            chk("err",       32'(err),      32'(e_err));
            chk("i_rdata",   i_rdata,       e_irdata);
            chk("d_rdata",   d_rdata,       e_drdata);
            chk("mem_we",    32'(mem_we),   32'(e_mwe));
            chk("mem_size",  32'(mem_size), 32'(e_msize));
            chk("mem_addr",  mem_addr,      e_maddr);
            chk("mem_wdata", mem_wdata,     e_mwdata);
            if (i_ack || d_ack) begin
                ack_t r;
                r.cyc = cyc; r.d = d_ack; r.err = err;
                r.rdata = d_ack ? d_rdata : i_rdata;
                alog.push_back(r);
            end
        end
    end

    initial begin
        txn_t        cur;
        bit          act = 1'b0;
        int          g = 0, a = 0, iss_end = 0, burst = 0, late_cyc = -1;
        bit          cur_err = 1'b0;
        logic [31:0] cur_rdata = '0;
        bit          ir, dr, gd, rst_now, in_issue, in_wait, sched_v;
        int          exp_cyc[13] = '{5, 15, 23, 27, 35, 39, 43, 47, 51, 55, 77, 89, 104};
        bit          exp_d[13]   = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 1};
        logic [31:0] exp_rd[13]  = '{32'h00500093, 32'h11111111, 32'hB1, 32'hA1, 32'hD2,
                                     32'hD3, 32'hD4, 32'hD5, 32'hC2, 32'hD6, 32'h0,
                                     32'hA3, 32'hE8};
        bit          exp_err[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

        // Single fetch, store with waits, simultaneous pair, starvation, timeout, reset in WAIT.
        iq.push_back(mk(0, 0, 3'b010, 32'h10,  0, 32'h00500093, 2, 0, 0, 0));
        dq.push_back(mk(1, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h11111111, 8, 2, 2, 0));
        iq.push_back(mk(0, 0, 3'b010, 32'h20,  0, 32'hA1, 20, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b100, 32'h200, 0, 32'hB1, 20, 0, 0, 0));
        iq.push_back(mk(0, 0, 3'b010, 32'h30,  0, 32'hC2, 32, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h300, 0, 32'hD2, 32, 0, 0, 0));
        dq.push_back(mk(1, 1, 3'b001, 32'h304, 32'h0000BEEF, 32'hD3, 32, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h308, 0, 32'hD4, 32, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h30C, 0, 32'hD5, 32, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h310, 0, 32'hD6, 32, 0, 0, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h400, 0, 32'h77, 60, 0, -1, 1));
        iq.push_back(mk(0, 0, 3'b010, 32'h40,  0, 32'hA3, 82, 3, 1, 0));
        iq.push_back(mk(0, 0, 3'b010, 32'h50,  0, 32'hA4, 95, 0, 5, 0));
        dq.push_back(mk(1, 0, 3'b010, 32'h500, 0, 32'hE8, 101, 0, 0, 0));

        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; d_size = 0; i_addr = 0; d_addr = 0;
        d_wdata = 0; mem_ready = 0; mem_valid = 0; mem_rdata = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk); #1;
            cyc = c;
            rst_now = (c < 2) || (c == RST_AT);

            if (c >= 1 && ((c - 1) < 2 || (c - 1) == RST_AT)) begin
                if (act) begin
                    if (cur.d) void'(dq.pop_front());
                    else       void'(iq.pop_front());
                end
                act = 0; burst = 0; late_cyc = -1;
                e_err = 0; e_irdata = 0; e_drdata = 0;
                e_mwe = 0; e_msize = 0; e_maddr = 0; e_mwdata = 0;
            end
            if (act && c > a) act = 0;
            if (act && c == g + 1) begin
                e_mwe    = cur.d ? cur.we : 1'b0;
                e_msize  = cur.d ? cur.size : 3'b010;
                e_maddr  = cur.addr;
                e_mwdata = cur.d ? cur.wdata : 32'h0;
            end

            ir = (iq.size() > 0) && (iq[0].start <= c);
            dr = (dq.size() > 0) && (dq[0].start <= c);
            i_req   = ir;
            i_addr  = ir ? iq[0].addr  : $urandom();
            d_req   = dr;
            d_we    = dr ? dq[0].we    : 1'($urandom_range(0, 1));
            d_size  = dr ? dq[0].size  : 3'($urandom_range(0, 7));
            d_addr  = dr ? dq[0].addr  : $urandom();
            d_wdata = dr ? dq[0].wdata : $urandom();

            if (!act && !rst_now && (ir || dr)) begin
                gd    = dr && !(ir && burst == MAXB);
                cur   = gd ? dq[0] : iq[0];
                burst = (gd && ir) ? ((burst + 1 > MAXB) ? MAXB : burst + 1) : 0;
                act   = 1; g = c;
                if (cur.vd < 0 || cur.rd + cur.vd + 2 > T) begin
                    a = g + T + 1; cur_err = 1; cur_rdata = 0;
                end else begin
                    a = g + 3 + cur.rd + cur.vd; cur_err = 0; cur_rdata = cur.rdata;
                end
                iss_end = (g + 1 + cur.rd < g + T) ? g + 1 + cur.rd : g + T;
            end

            in_issue = act && c > g && c <= iss_end;
            in_wait  = act && c > g + 1 + cur.rd && c < a;
            sched_v  = in_wait && cur.vd >= 0 && c == g + 2 + cur.rd + cur.vd;
            mem_ready = in_issue ? (c == g + 1 + cur.rd) : 1'($urandom_range(0, 1));
            mem_valid = in_wait ? sched_v : ((c == late_cyc) || ($urandom_range(0, 3) == 0));
            mem_rdata = sched_v ? cur.rdata : ((c == late_cyc) ? 32'hFFFFFFFF : $urandom());
            rst = rst_now;

            e_busy = act && c > g;
            e_mreq = in_issue;
            e_iack = act && c == a && !cur.d;
            e_dack = act && c == a && cur.d;
            if (act && c == a) begin
                e_err = cur_err;
                if (cur.d) begin e_drdata = cur_rdata; void'(dq.pop_front()); end
                else       begin e_irdata = cur_rdata; void'(iq.pop_front()); end
                if (cur_err && cur.late) late_cyc = a + 1;
            end
            chk_en = (c >= 1);
        end

        chk("ack_count", 32'(alog.size()), 32'd13);
        for (int i = 0; i < 13 && i < alog.size(); i++) begin
            chk($sformatf("ack%0d_cycle", i), 32'(alog[i].cyc),  32'(exp_cyc[i]));
            chk($sformatf("ack%0d_owner", i), 32'(alog[i].d),    32'(exp_d[i]));
            chk($sformatf("ack%0d_rdata", i), alog[i].rdata,     exp_rd[i]);
            chk($sformatf("ack%0d_err", i),   32'(alog[i].err),  32'(exp_err[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
